inst_fifo: RTL and testbench
============================

# inst_fifo

Dual-port instruction queue between fetch and the dual-issue decode stage. Fetch writes up to two instructions per cycle with their PCs. Decode/issue pops one (master only) or two (master + slave) per cycle. The block produces the `empty` / `almost_empty` status that gates slave issue, plus a `full` back-pressure flag for fetch. On redirect it supports a flush that can retain the branch delay-slot instruction.

## Interface
- `DEPTH`, 16, number of entries; power of two, ≥ 4.
- `DATA_W`, 32, instruction and PC width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  discard queue contents (pipeline redirect).
- `flush_keep_ds`  in  1  on flush, retain the delay-slot entry (active only with the macro).
- `write_en1`, `write_en2`  in  1 each  push slot 1 / slot 2; `write_en2` is legal only with `write_en1`.
- `write_inst1`, `write_inst2`  in  DATA_W each  instruction words.
- `write_pc1`, `write_pc2`  in  DATA_W each  instruction addresses.
- `read_en1`  in  1  pop head (master issued).
- `read_en2`  in  1  pop head+1 (slave issued); legal only with `read_en1`.
- `read_inst1`, `read_pc1`  out  DATA_W each  entry at head.
- `read_inst2`, `read_pc2`  out  DATA_W each  entry at head+1.
- `empty`  out  1  count == 0.
- `almost_empty`  out  1  count == 1.
- `full`  out  1  count > DEPTH−2, i.e. fewer than two free entries.
- `count`  out  log2(DEPTH)+1  occupancy.

## Operation
- Storage: circular buffer of {inst, pc}.
  - `wptr` and `rptr` are log2(DEPTH) bits and wrap modulo DEPTH.
  - `count` is held as a separate register.
- Reads:
  - `read_*1` is the combinational view of `mem[rptr]`.
  - `read_*2` is the combinational view of `mem[rptr+1 mod DEPTH]`.
  - Read data is meaningful only when count covers the slot.
- Pops: `nread = read_en1 + read_en2`.
  - `read_en1` with count == 0 is ignored.
  - `read_en2` with count < 2 is ignored; `read_en1` in the same cycle still pops.
  - `rptr += nread`.
- Pushes: `nwrite = write_en1 + write_en2`.
  - All writes in a cycle are dropped when `full` is 1. `full` is evaluated on the pre-update count, and pops in the same cycle do not free space for that cycle.
  - Slot 1 goes to `wptr`, slot 2 to `wptr+1`; then `wptr += nwrite`.
- Next state: `count_next = count + nwrite − nread`. Simultaneous push and pop are always legal.
- There is no write-to-read bypass: a pushed entry becomes visible the cycle after it is written, even when the queue is empty.
- Flush takes priority over all pushes and pops in that cycle.
  - Without retention: `rptr = wptr = 0`, `count = 0`.
  - With retention (see Configuration):
    - The retained entry is the one that would be at the head after this cycle's pops (`mem[rptr+nread]`) if `count − nread ≥ 1`.
    - Otherwise, if `write_en1` is 1, the retained entry is `write_inst1`/`write_pc1`.
    - Otherwise nothing is retained.
    - The retained entry is written to `mem[0]`; `rptr = 0`, `wptr = 1`, `count = 1`.
- Reset: `rptr`, `wptr` and `count` are 0, and all storage is cleared to 0.
  - Reset outputs: `empty = 1`, `almost_empty = 0`, `full = 0`, `count = 0`, all read data = 0.
- Illegal combinations (`write_en2` without `write_en1`, `read_en2` without `read_en1`) are treated as that enable being 0.

## Timing
- Push-to-visible latency is 1 cycle: data written at edge N appears on `read_*` and in `count` after edge N.
- Flags are combinational decodes of the registered `count`, so they are stable for the whole cycle.
- Issue logic may use `empty`/`almost_empty` in the same cycle it drives `read_en*`. `read_en*` must not feed back into the flags.
- Flush and reset both take effect at the next edge. Reset dominates flush.
- Wrap-around: with `rptr = DEPTH−1`, `read_*2` returns `mem[0]`. A two-entry push at `wptr = DEPTH−1` writes entries DEPTH−1 and 0.

## Configuration
- `INST_FIFO_DS_KEEP_EN` defined: `flush` with `flush_keep_ds = 1` performs delay-slot retention as described in Operation.
- Not defined: the `flush_keep_ds` port remains but is ignored, and every flush empties the queue (`count = 0`).

## Test plan
- Reset, push 2 (pc 0x100, 0x104), no pop → next cycle `count = 2`, `empty = 0`, `almost_empty = 0`, `read_pc1 = 0x100`, `read_pc2 = 0x104`.
- Fill to DEPTH−1 = 15 entries → `full = 1`. A push of 2 in that cycle is dropped, and a simultaneous single pop leaves `count = 14`.
- Place `rptr` at 15 with 3 entries, pop 2 → data taken from entries 15 and 0, `rptr = 1`, `count = 1`, `almost_empty = 1`.
- `count = 1` with `read_en1 = read_en2 = 1` → only one pop, `count = 0`, `empty = 1`.
- With the macro, `count = 3`, pop 1, flush with keep → next cycle `count = 1` and `read_pc1` = the pc of the original second entry. Without the macro, same stimulus → `count = 0`.
- Push during reset or during flush (keep = 0) → ignored, `count = 0`.

Source files
------------

// File: rtl/inst_fifo_if.sv
// Instruction-queue bus between fetch/issue (master) and the queue (slave).
// Groups the push, pop and flush controls with the read data and status flags.
interface inst_fifo_if #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Redirect control
    logic              flush;
    logic              flush_keep_ds;

    // Push side (fetch)
    logic              write_en1;
    logic              write_en2;
    logic [DATA_W-1:0] write_inst1;
    logic [DATA_W-1:0] write_inst2;
    logic [DATA_W-1:0] write_pc1;
    logic [DATA_W-1:0] write_pc2;

    // Pop side (decode/issue)
    logic              read_en1;
    logic              read_en2;
    logic [DATA_W-1:0] read_inst1;
    logic [DATA_W-1:0] read_pc1;
    logic [DATA_W-1:0] read_inst2;
    logic [DATA_W-1:0] read_pc2;

    // Status
    logic              empty;
    logic              almost_empty;
    logic              full;
    logic [CW-1:0]     count;

    modport master (
        output flush, flush_keep_ds,
        output write_en1, write_en2, write_inst1, write_inst2, write_pc1, write_pc2,
        output read_en1, read_en2,
        input  read_inst1, read_pc1, read_inst2, read_pc2,
        input  empty, almost_empty, full, count
    );

    modport slave (
        input  flush, flush_keep_ds,
        input  write_en1, write_en2, write_inst1, write_inst2, write_pc1, write_pc2,
        input  read_en1, read_en2,
        output read_inst1, read_pc1, read_inst2, read_pc2,
        output empty, almost_empty, full, count
    );
endinterface

// File: rtl/inst_fifo.sv
// inst_fifo: dual-push / dual-pop instruction queue between fetch and the
// dual-issue decode stage. Circular buffer of {inst, pc} with a separate
// occupancy counter; flags decode the registered count only.
// Optional feature: define INST_FIFO_DS_KEEP_EN to let a flush with
// flush_keep_ds retain the branch delay-slot instruction.
module inst_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    inst_fifo_if.slave fif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] inst_mem [DEPTH];
    logic [DATA_W-1:0] pc_mem   [DEPTH];

    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [CW-1:0] count;

    logic [AW-1:0] rptr_p1;
    logic [AW-1:0] wptr_p1;
    logic          full_int;
    logic          rd1;
    logic          rd2;
    logic          wr1;
    logic          wr2;
    logic [1:0]    nread;
    logic [1:0]    nwrite;

    assign rptr_p1  = rptr + AW'(1);
    assign wptr_p1  = wptr + AW'(1);
    assign full_int = (count > CW'(DEPTH - 2));

    // Status flags and read views depend only on registered state, never on read_en*.
    assign fif.empty        = (count == '0);
    assign fif.almost_empty = (count == CW'(1));
    assign fif.full         = full_int;
    assign fif.count        = count;
    assign fif.read_inst1   = inst_mem[rptr];
    assign fif.read_pc1     = pc_mem[rptr];
    assign fif.read_inst2   = inst_mem[rptr_p1];
    assign fif.read_pc2     = pc_mem[rptr_p1];

    // Qualify pops against occupancy and pushes against the pre-update full flag.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        rd1    = 1'b0;
        rd2    = 1'b0;
        wr1    = 1'b0;
        wr2    = 1'b0;
        if (fif.read_en1 && (count != '0)) begin
            rd1 = 1'b1;
            rd2 = fif.read_en2 && (count >= CW'(2));
        end
        if (fif.write_en1 && !full_int) begin
            wr1 = 1'b1;
            wr2 = fif.write_en2;
        end
        nread  = {1'b0, rd1} + {1'b0, rd2};
        nwrite = {1'b0, wr1} + {1'b0, wr2};
    end

`ifdef INST_FIFO_DS_KEEP_EN
    logic [CW-1:0]     count_after_pop;
    logic [AW-1:0]     keep_ptr;
    logic              keep_valid;
    logic [DATA_W-1:0] keep_inst;
    logic [DATA_W-1:0] keep_pc;

    // Pick the delay-slot entry: the post-pop head if one survives, else the slot-1 push.
    always_comb begin
        count_after_pop = count - CW'(nread);
        keep_ptr        = rptr + AW'(nread);
        keep_valid      = 1'b0;
        keep_inst       = '0;
        keep_pc         = '0;
        if (count_after_pop != '0) begin
            keep_valid = 1'b1;
            keep_inst  = inst_mem[keep_ptr];
            keep_pc    = pc_mem[keep_ptr];
        end else if (fif.write_en1) begin
            keep_valid = 1'b1;
            keep_inst  = fif.write_inst1;
            keep_pc    = fif.write_pc1;
        end
    end
`else
    // Retention is compiled out; the port stays for a uniform interface.
    logic unused_keep_ds;
    assign unused_keep_ds = fif.flush_keep_ds;
`endif

    // Pointer, count and storage update; reset dominates flush, flush dominates push/pop.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            // NOTE: storage is cleared on reset so read data is defined as 0; this puts a reset on every storage flop.
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (fif.flush) begin
`ifdef INST_FIFO_DS_KEEP_EN
            if (fif.flush_keep_ds && keep_valid) begin
                inst_mem[0] <= keep_inst;
                pc_mem[0]   <= keep_pc;
                rptr        <= '0;
                wptr        <= AW'(1);
                count       <= CW'(1);
            end else begin
                rptr  <= '0;
                wptr  <= '0;
                count <= '0;
            end
`else
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
`endif
        end else begin
            if (wr1) begin
                inst_mem[wptr] <= fif.write_inst1;
                pc_mem[wptr]   <= fif.write_pc1;
            end
            if (wr2) begin
                inst_mem[wptr_p1] <= fif.write_inst2;
                pc_mem[wptr_p1]   <= fif.write_pc2;
            end
            rptr  <= rptr + AW'(nread);
            wptr  <= wptr + AW'(nwrite);
            count <= count + CW'(nwrite) - CW'(nread);
        end
    end
endmodule

// File: tb/tb_inst_fifo.sv
// Directed testbench for inst_fifo (DEPTH 16, DATA_W 32).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// after the rising edge that updates state.
module tb_inst_fifo;
    localparam logic [31:0] INST_XOR = 32'hA5A5_0000;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    inst_fifo_if #(.DEPTH(16), .DATA_W(32)) bus ();

    inst_fifo #(.DEPTH(16), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .fif (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic we1, input logic we2,
                          input logic [31:0] pc1, input logic [31:0] pc2,
                          input logic re1, input logic re2,
                          input logic fl, input logic keep);
        bus.write_en1     = we1;
        bus.write_en2     = we2;
        bus.write_pc1     = pc1;
        bus.write_pc2     = pc2;
        bus.write_inst1   = pc1 ^ INST_XOR;
        bus.write_inst2   = pc2 ^ INST_XOR;
        bus.read_en1      = re1;
        bus.read_en2      = re2;
        bus.flush         = fl;
        bus.flush_keep_ds = keep;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step(input logic we1, input logic we2,
                        input logic [31:0] pc1, input logic [31:0] pc2,
                        input logic re1, input logic re2,
                        input logic fl, input logic keep);
        set_in(we1, we2, pc1, pc2, re1, re2, fl, keep);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b1, 1'b1, 32'hDEAD_0000, 32'hDEAD_0004, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'hDEAD_0008, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", bus.count); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b expected 1", bus.empty); end
        checks++; if (bus.almost_empty !== 1'b0) begin errors++; $display("FAIL reset_almost_empty got %b expected 0", bus.almost_empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b expected 0", bus.full); end
        checks++; if (bus.read_pc1 !== 32'h0) begin errors++; $display("FAIL reset_pc1 got %h expected 0", bus.read_pc1); end
        checks++; if (bus.read_inst1 !== 32'h0) begin errors++; $display("FAIL reset_inst1 got %h expected 0", bus.read_inst1); end
        checks++; if (bus.read_pc2 !== 32'h0) begin errors++; $display("FAIL reset_pc2 got %h expected 0", bus.read_pc2); end
        checks++; if (bus.read_inst2 !== 32'h0) begin errors++; $display("FAIL reset_inst2 got %h expected 0", bus.read_inst2); end
    endtask

    task automatic test_push2();
        set_in(1'b1, 1'b1, 32'h100, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL nobypass_empty got %b expected 1", bus.empty); end
        checks++; if (bus.read_pc1 !== 32'h0) begin errors++; $display("FAIL nobypass_pc1 got %h expected 0", bus.read_pc1); end
        tick();
        checks++; if (bus.count !== 5'd2) begin errors++; $display("FAIL push2_count got %0d expected 2", bus.count); end
        checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL push2_empty got %b expected 0", bus.empty); end
        checks++; if (bus.almost_empty !== 1'b0) begin errors++; $display("FAIL push2_almost_empty got %b expected 0", bus.almost_empty); end
        checks++; if (bus.read_pc1 !== 32'h100) begin errors++; $display("FAIL push2_pc1 got %h expected 100", bus.read_pc1); end
        checks++; if (bus.read_pc2 !== 32'h104) begin errors++; $display("FAIL push2_pc2 got %h expected 104", bus.read_pc2); end
        checks++; if (bus.read_inst1 !== (32'h100 ^ INST_XOR)) begin errors++; $display("FAIL push2_inst1 got %h expected %h", bus.read_inst1, 32'h100 ^ INST_XOR); end
        checks++; if (bus.read_inst2 !== (32'h104 ^ INST_XOR)) begin errors++; $display("FAIL push2_inst2 got %h expected %h", bus.read_inst2, 32'h104 ^ INST_XOR); end
        // read_en2 without read_en1 is treated as no pop
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.count !== 5'd2) begin errors++; $display("FAIL illegal_re2_count got %0d expected 2", bus.count); end
        // write_en2 without write_en1 is treated as no push
        step(1'b0, 1'b1, 32'h0, 32'h1F0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.count !== 5'd2) begin errors++; $display("FAIL illegal_we2_count got %0d expected 2", bus.count); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 7; i++)
            step(1'b1, 1'b1, 32'h200 + 32'(8 * i), 32'h204 + 32'(8 * i), 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.count !== 5'd14) begin errors++; $display("FAIL fill14_count got %0d expected 14", bus.count); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL fill14_full got %b expected 0", bus.full); end
        step(1'b1, 1'b0, 32'h238, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.count !== 5'd15) begin errors++; $display("FAIL fill15_count got %0d expected 15", bus.count); end
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fill15_full got %b expected 1", bus.full); end
        step(1'b1, 1'b1, 32'h900, 32'h904, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.count !== 5'd14) begin errors++; $display("FAIL fulldrop_count got %0d expected 14", bus.count); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL fulldrop_full got %b expected 0", bus.full); end
        checks++; if (bus.read_pc1 !== 32'h204) begin errors++; $display("FAIL fulldrop_pc1 got %h expected 204", bus.read_pc1); end
    endtask

    task automatic test_wrap();
        do_reset();
        step(1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k < 15; k++)
            step(1'b1, 1'b0, 32'h300 + 32'(4 * k), 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h33C, 32'h340, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h344, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.count !== 5'd3) begin errors++; $display("FAIL wrap_count3 got %0d expected 3", bus.count); end
        checks++; if (bus.read_pc1 !== 32'h33C) begin errors++; $display("FAIL wrap_pc1 got %h expected 33c", bus.read_pc1); end
        checks++; if (bus.read_pc2 !== 32'h340) begin errors++; $display("FAIL wrap_pc2 got %h expected 340", bus.read_pc2); end
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (bus.count !== 5'd3) begin errors++; $display("FAIL flags_comb_count got %0d expected 3", bus.count); end
        tick();
        checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL wrap_pop2_count got %0d expected 1", bus.count); end
        checks++; if (bus.almost_empty !== 1'b1) begin errors++; $display("FAIL wrap_almost_empty got %b expected 1", bus.almost_empty); end
        checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL wrap_empty got %b expected 0", bus.empty); end
        checks++; if (bus.read_pc1 !== 32'h344) begin errors++; $display("FAIL wrap_head_pc got %h expected 344", bus.read_pc1); end
    endtask

    task automatic test_overpop();
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL overpop_count got %0d expected 0", bus.count); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL overpop_empty got %b expected 1", bus.empty); end
        checks++; if (bus.almost_empty !== 1'b0) begin errors++; $display("FAIL overpop_almost_empty got %b expected 0", bus.almost_empty); end
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL emptypop_count got %0d expected 0", bus.count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1'b1, 1'b1, 32'h500, 32'h504, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h508, 32'h50C, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.count !== 5'd2) begin errors++; $display("FAIL b2b1_count got %0d expected 2", bus.count); end
        checks++; if (bus.read_pc1 !== 32'h508) begin errors++; $display("FAIL b2b1_pc1 got %h expected 508", bus.read_pc1); end
        checks++; if (bus.read_pc2 !== 32'h50C) begin errors++; $display("FAIL b2b1_pc2 got %h expected 50c", bus.read_pc2); end
        step(1'b1, 1'b1, 32'h510, 32'h514, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.count !== 5'd2) begin errors++; $display("FAIL b2b2_count got %0d expected 2", bus.count); end
        checks++; if (bus.read_pc1 !== 32'h510) begin errors++; $display("FAIL b2b2_pc1 got %h expected 510", bus.read_pc1); end
        checks++; if (bus.read_pc2 !== 32'h514) begin errors++; $display("FAIL b2b2_pc2 got %h expected 514", bus.read_pc2); end
    endtask

    task automatic test_flush();
        do_reset();
        step(1'b1, 1'b1, 32'h400, 32'h404, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h408, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.count !== 5'd3) begin errors++; $display("FAIL flush_pre_count got %0d expected 3", bus.count); end
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
`ifdef INST_FIFO_DS_KEEP_EN
        checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL keep_mem_count got %0d expected 1", bus.count); end
        checks++; if (bus.read_pc1 !== 32'h404) begin errors++; $display("FAIL keep_mem_pc1 got %h expected 404", bus.read_pc1); end
        checks++; if (bus.read_inst1 !== (32'h404 ^ INST_XOR)) begin errors++; $display("FAIL keep_mem_inst1 got %h expected %h", bus.read_inst1, 32'h404 ^ INST_XOR); end
`else
        checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL keep_off_count got %0d expected 0", bus.count); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL keep_off_empty got %b expected 1", bus.empty); end
`endif
        // Empty the queue, then flush-with-keep while fetch pushes slot 1
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL flush_plain_count got %0d expected 0", bus.count); end
        step(1'b1, 1'b0, 32'h480, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
`ifdef INST_FIFO_DS_KEEP_EN
        checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL keep_wr_count got %0d expected 1", bus.count); end
        checks++; if (bus.read_pc1 !== 32'h480) begin errors++; $display("FAIL keep_wr_pc1 got %h expected 480", bus.read_pc1); end
`else
        checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL keep_off_wr_count got %0d expected 0", bus.count); end
`endif
        step(1'b1, 1'b1, 32'h490, 32'h494, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL flush_push_count got %0d expected 0", bus.count); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL flush_push_empty got %b expected 1", bus.empty); end
        step(1'b1, 1'b0, 32'h4A0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL post_flush_count got %0d expected 1", bus.count); end
        checks++; if (bus.read_pc1 !== 32'h4A0) begin errors++; $display("FAIL post_flush_pc1 got %h expected 4a0", bus.read_pc1); end
    endtask

    task automatic test_push_during_reset();
        step(1'b1, 1'b1, 32'h4B0, 32'h4B4, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b1, 1'b1, 32'h4C0, 32'h4C4, 1'b0, 1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL rst_push_count got %0d expected 0", bus.count); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rst_push_empty got %b expected 1", bus.empty); end
        checks++; if (bus.read_pc1 !== 32'h0) begin errors++; $display("FAIL rst_clear_pc1 got %h expected 0", bus.read_pc1); end
        checks++; if (bus.read_pc2 !== 32'h0) begin errors++; $display("FAIL rst_clear_pc2 got %h expected 0", bus.read_pc2); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_push2();
        test_full();
        test_wrap();
        test_overpop();
        test_back_to_back();
        test_flush();
        test_push_during_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
